// File: rtl/ysyx_23060184_csr_exu.sv
// CSR execution unit: sequences Zicsr read-modify-write ops and ECALL/MRET
// into one-cycle strobes on the CSR file port, then hands the old CSR value
// and any PC redirect to writeback over a valid/ready handshake.
module ysyx_23060184_csr_exu #(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_funct3,
  input  logic                  in_mret,
  input  logic [11:0]           in_csr,
  input  logic [4:0]            in_rs1_idx,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [CSR_AW-1:0]     csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [CSR_AW-1:0]     csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  output logic                  csr_ecall,
  output logic                  csr_mret,
  output logic [DATA_WIDTH-1:0] csr_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rd_data,
  output logic                  out_redirect,
  output logic [DATA_WIDTH-1:0] out_next_pc,
  output logic                  out_illegal
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, RESP} state_e;

  state_e                state_q;
  logic [2:0]            funct3_q;
  logic                  is_mret_q;
  logic                  illegal_q;
  logic [4:0]            rs1_idx_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [CSR_AW-1:0]     addr_q;

  logic [CSR_AW-1:0]     raddr_q, waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, pc_q, rd_data_q, next_pc_q;
  logic                  wen_q, ecall_q, mret_q, valid_q, redirect_q, illegal_out_q;

  logic                  csr_legal;
  logic [DATA_WIDTH-1:0] src;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  wen_d;

  // Decode request legality and the read-modify-write result
  always_comb begin
    csr_legal = (in_csr == 12'h300) || (in_csr == 12'h305) ||
                (in_csr == 12'h341) || (in_csr == 12'h342);
    src = funct3_q[2] ? {{(DATA_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_data_q;
    wdata_d = src;
    case (funct3_q[1:0])
      2'b10:   wdata_d = csr_rdata | src;
      2'b11:   wdata_d = csr_rdata & ~src;
      default: wdata_d = src;
    endcase
    // set/clear forms with rs1=x0 must not write
    wen_d = !(funct3_q[1] && (rs1_idx_q == 5'd0));
  end

  // Control FSM with registered strobes and response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      funct3_q      <= '0;
      is_mret_q     <= 1'b0;
      illegal_q     <= 1'b0;
      rs1_idx_q     <= '0;
      rs1_data_q    <= '0;
      addr_q        <= '0;
      raddr_q       <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      pc_q          <= '0;
      rd_data_q     <= '0;
      next_pc_q     <= '0;
      wen_q         <= 1'b0;
      ecall_q       <= 1'b0;
      mret_q        <= 1'b0;
      valid_q       <= 1'b0;
      redirect_q    <= 1'b0;
      illegal_out_q <= 1'b0;
    end else begin
      wen_q   <= 1'b0;
      ecall_q <= 1'b0;
      mret_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            funct3_q      <= in_funct3;
            is_mret_q     <= (in_funct3 == 3'b000) && in_mret;
            illegal_q     <= (in_funct3 == 3'b100) ||
                             ((in_funct3 != 3'b000) && !csr_legal);
            rs1_idx_q     <= in_rs1_idx;
            rs1_data_q    <= in_rs1_data;
            addr_q        <= in_csr[CSR_AW-1:0];
            raddr_q       <= in_csr[CSR_AW-1:0];
            rd_data_q     <= '0;
            next_pc_q     <= '0;
            redirect_q    <= 1'b0;
            illegal_out_q <= 1'b0;
            if ((in_funct3 == 3'b000) && !in_mret) begin
              ecall_q <= 1'b1;
              pc_q    <= in_pc;
              wdata_q <= DATA_WIDTH'(11);
              state_q <= TRAP;
            end else begin
              mret_q  <= (in_funct3 == 3'b000) && in_mret;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (is_mret_q) begin
            next_pc_q  <= csr_rdata;
            redirect_q <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= RESP;
          end else if (illegal_q) begin
            illegal_out_q <= 1'b1;
            valid_q       <= 1'b1;
            state_q       <= RESP;
          end else begin
            waddr_q   <= addr_q;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            rd_data_q <= csr_rdata;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        TRAP: begin
          next_pc_q  <= csr_rdata;
          redirect_q <= 1'b1;
          valid_q    <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign csr_raddr    = raddr_q;
  assign csr_waddr    = waddr_q;
  assign csr_wdata    = wdata_q;
  assign csr_wen      = wen_q;
  assign csr_ecall    = ecall_q;
  assign csr_mret     = mret_q;
  assign csr_pc       = pc_q;
  assign out_valid    = valid_q;
  assign out_rd_data  = rd_data_q;
  assign out_redirect = redirect_q;
  assign out_next_pc  = next_pc_q;
  assign out_illegal  = illegal_out_q;

endmodule

// File: tb/tb_ysyx_23060184_csr_exu.sv
// Directed bench for the CSR execution unit with a small behavioural CSR file.
module tb_ysyx_23060184_csr_exu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic        in_mret = 1'b0;
  logic [11:0] in_csr = '0;
  logic [4:0]  in_rs1_idx = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_pc = '0;
  logic [9:0]  csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, csr_pc;
  logic        csr_wen, csr_ecall, csr_mret;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rd_data, out_next_pc;
  logic        out_redirect, out_illegal;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // behavioural CSR file
  logic [31:0] m_mstatus = 32'h0000_1800;
  logic [31:0] m_mtvec   = '0;
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;

  // observations collected during one instruction
  int          lat;
  int          n_wen, n_ecall, n_mret;
  logic [31:0] w_addr, w_data, e_pc, e_wdata;

  ysyx_23060184_csr_exu #(.DATA_WIDTH(32), .CSR_AW(10)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_mret(in_mret), .in_csr(in_csr),
    .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data), .in_pc(in_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_ecall(csr_ecall), .csr_mret(csr_mret), .csr_pc(csr_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_data(out_rd_data), .out_redirect(out_redirect),
    .out_next_pc(out_next_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // CSR file read port: trap/return selects override the address
  always_comb begin
    csr_rdata = '0;
    if (csr_ecall)     csr_rdata = m_mtvec;
    else if (csr_mret) csr_rdata = m_mepc;
    else begin
      case (csr_raddr)
        10'h300: csr_rdata = m_mstatus;
        10'h305: csr_rdata = m_mtvec;
        10'h341: csr_rdata = m_mepc;
        10'h342: csr_rdata = m_mcause;
        default: csr_rdata = '0;
      endcase
    end
  end

  // CSR file write port
  always_ff @(posedge clk) begin
    if (csr_ecall) begin
      m_mepc   <= csr_pc;
      m_mcause <= csr_wdata;
    end else if (csr_wen) begin
      case (csr_waddr)
        10'h300: m_mstatus <= csr_wdata;
        10'h305: m_mtvec   <= csr_wdata;
        10'h341: m_mepc    <= csr_wdata;
        10'h342: m_mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present one request, then watch strobes until out_valid (bounded)
  task automatic issue(input logic [2:0] f3, input logic m, input logic [11:0] csr,
                       input logic [4:0] idx, input logic [31:0] d, input logic [31:0] pc);
    @(negedge clk);
    in_funct3 = f3; in_mret = m; in_csr = csr;
    in_rs1_idx = idx; in_rs1_data = d; in_pc = pc;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; n_wen = 0; n_ecall = 0; n_mret = 0;
    w_addr = '0; w_data = '0; e_pc = '0; e_wdata = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (csr_wen)   begin n_wen++; w_addr = 32'(csr_waddr); w_data = csr_wdata; end
      if (csr_ecall) begin n_ecall++; e_pc = csr_pc; e_wdata = csr_wdata; end
      if (csr_mret)  n_mret++;
      if (out_valid) begin lat = c; break; end
    end
  endtask

  task automatic accept_resp();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("in_ready_after_resp", 32'(in_ready), 32'd1);
  endtask

  logic [31:0] snap_rd;

  initial begin
    // reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_wen", 32'(csr_wen), 32'd0);
    check("rst_next_pc", out_next_pc, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // CSRRW mtvec
    issue(3'b001, 1'b0, 12'h305, 5'd3, 32'h8000_0100, 32'h0);
    check("rw_lat", 32'(lat), 32'd3);
    check("rw_nwen", 32'(n_wen), 32'd1);
    check("rw_waddr", w_addr, 32'h305);
    check("rw_wdata", w_data, 32'h8000_0100);
    check("rw_rd", out_rd_data, 32'h0);
    check("rw_redirect", 32'(out_redirect), 32'd0);
    accept_resp();

    // CSRRS mstatus with x0: read only
    issue(3'b010, 1'b0, 12'h300, 5'd0, 32'hFFFF_FFFF, 32'h0);
    check("rs0_lat", 32'(lat), 32'd3);
    check("rs0_nwen", 32'(n_wen), 32'd0);
    check("rs0_rd", out_rd_data, 32'h1800);
    accept_resp();

    // CSRRCI mstatus uimm=8
    issue(3'b111, 1'b0, 12'h300, 5'd8, 32'h0, 32'h0);
    check("rci_nwen", 32'(n_wen), 32'd1);
    check("rci_wdata", w_data, 32'h1800);
    check("rci_rd", out_rd_data, 32'h1800);
    accept_resp();

    // read back mtvec written earlier
    issue(3'b010, 1'b0, 12'h305, 5'd0, 32'h0, 32'h0);
    check("rb_mtvec", out_rd_data, 32'h8000_0100);
    accept_resp();

    // CSRRSI mstatus uimm=3: 0x1800|3
    issue(3'b110, 1'b0, 12'h300, 5'd3, 32'h0, 32'h0);
    check("rsi_wdata", w_data, 32'h1803);
    accept_resp();

    // ECALL
    issue(3'b000, 1'b0, 12'h000, 5'd0, 32'h0, 32'h8000_0040);
    check("ecall_lat", 32'(lat), 32'd2);
    check("ecall_n", 32'(n_ecall), 32'd1);
    check("ecall_pc", e_pc, 32'h8000_0040);
    check("ecall_wdata", e_wdata, 32'd11);
    check("ecall_nwen", 32'(n_wen), 32'd0);
    check("ecall_redirect", 32'(out_redirect), 32'd1);
    check("ecall_next_pc", out_next_pc, 32'h8000_0100);
    check("ecall_rd", out_rd_data, 32'h0);
    accept_resp();

    // mcause after trap
    issue(3'b010, 1'b0, 12'h342, 5'd0, 32'h0, 32'h0);
    check("rb_mcause", out_rd_data, 32'd11);
    accept_resp();

    // MRET returns mepc as stored
    issue(3'b000, 1'b1, 12'h302, 5'd0, 32'h0, 32'h0);
    check("mret_lat", 32'(lat), 32'd2);
    check("mret_n", 32'(n_mret), 32'd1);
    check("mret_nwen", 32'(n_wen), 32'd0);
    check("mret_redirect", 32'(out_redirect), 32'd1);
    check("mret_next_pc", out_next_pc, 32'h8000_0040);
    accept_resp();

    // software bumps mepc, then MRET
    issue(3'b001, 1'b0, 12'h341, 5'd5, 32'h8000_0044, 32'h0);
    check("mepc_old", out_rd_data, 32'h8000_0040);
    accept_resp();
    issue(3'b000, 1'b1, 12'h302, 5'd0, 32'h0, 32'h0);
    check("mret2_next_pc", out_next_pc, 32'h8000_0044);
    accept_resp();

    // illegal CSR with writeback stall
    issue(3'b001, 1'b0, 12'h7C0, 5'd1, 32'h1234_5678, 32'h0);
    check("ill_lat", 32'(lat), 32'd2);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_rd", out_rd_data, 32'h0);
    check("ill_nwen", 32'(n_wen), 32'd0);
    snap_rd = out_rd_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (csr_wen) n_wen++;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_illegal", 32'(out_illegal), 32'd1);
      check("stall_rd", out_rd_data, snap_rd);
    end
    check("stall_nwen", 32'(n_wen), 32'd0);
    accept_resp();

    // funct3=100 is illegal
    issue(3'b100, 1'b0, 12'h300, 5'd1, 32'h0, 32'h0);
    check("f3_100_ill", 32'(out_illegal), 32'd1);
    check("f3_100_nwen", 32'(n_wen), 32'd0);
    accept_resp();

    // upper CSR bits nonzero: aliasing to 0x300 must still be illegal
    issue(3'b010, 1'b0, 12'hB00, 5'd0, 32'h0, 32'h0);
    check("hi_bits_ill", 32'(out_illegal), 32'd1);
    check("hi_bits_rd", out_rd_data, 32'h0);
    accept_resp();

    // a legal op after illegal ones clears the flag
    issue(3'b010, 1'b0, 12'h300, 5'd0, 32'h0, 32'h0);
    check("legal_after_ill", 32'(out_illegal), 32'd0);
    check("mstatus_now", out_rd_data, 32'h1803);
    accept_resp();

    // reset asserted during WRITE
    @(negedge clk);
    in_funct3 = 3'b001; in_mret = 1'b0; in_csr = 12'h341;
    in_rs1_idx = 5'd2; in_rs1_data = 32'hDEAD_BEEF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);                 // READ
    @(negedge clk);                 // WRITE
    check("pre_rst_wen", 32'(csr_wen), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("arst_wen", 32'(csr_wen), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("arst_no_write", m_mepc, 32'h8000_0044);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_csr_exu.md
# ysyx_23060184_csr_exu

CSR execution unit for the NPC core. It sits between the issue/execute pipeline and the CSR register file. It sequences Zicsr read-modify-write instructions plus ECALL/MRET into single-purpose strobes on the CSR file's port (raddr/rdata, waddr/wdata/wen, ecall, mret, pc), then returns the old CSR value and any PC redirect to writeback over a valid/ready handshake. Only one instruction is in flight at a time.

## Interface
- DATA_WIDTH, 32: datapath and PC width.
- CSR_AW, 10: CSR file address width; the instruction's 12-bit CSR field is truncated to this width.
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept; high only in IDLE
- in_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 SYSTEM
- in_mret  in  1  with funct3=000: 1 = MRET, 0 = ECALL
- in_csr  in  12  instruction CSR field
- in_rs1_idx  in  5  rs1 index, or uimm for the *I forms
- in_rs1_data  in  DATA_WIDTH  rs1 value
- in_pc  in  DATA_WIDTH  instruction PC
- csr_raddr  out  CSR_AW  CSR file read address
- csr_rdata  in  DATA_WIDTH  CSR file read data; combinational from raddr/ecall/mret
- csr_waddr  out  CSR_AW  write address
- csr_wdata  out  DATA_WIDTH  write data; carries mcause during ECALL
- csr_wen  out  1  write strobe, one cycle
- csr_ecall  out  1  ECALL strobe, one cycle
- csr_mret  out  1  MRET read select
- csr_pc  out  DATA_WIDTH  PC presented with ECALL
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  writeback accepts
- out_rd_data  out  DATA_WIDTH  old CSR value; 0 for SYSTEM and illegal ops
- out_redirect  out  1  next_pc must be taken
- out_next_pc  out  DATA_WIDTH  mtvec (ECALL) or mepc (MRET)
- out_illegal  out  1  unsupported CSR or funct3=100

## Operation
- FSM states: IDLE, READ, WRITE, TRAP, RESP.
- IDLE: in_ready=1. On in_valid, latch all inputs.
  - SYSTEM/ECALL goes to TRAP.
  - Every other op goes to READ.
- READ: drive csr_raddr = latched csr[9:0]. For MRET also drive csr_mret=1. Capture csr_rdata into old.
  - MRET: next_pc=old, redirect=1, go to RESP.
  - Illegal op: rd_data=0, no write, go to RESP.
  - Otherwise go to WRITE.
- Operand src = rs1_data for funct3[2]=0, or zero-extended rs1_idx for funct3[2]=1.
- WRITE: csr_waddr = addr.
  - csr_wdata is src for RW/RWI, old|src for RS/RSI, old&~src for RC/RCI.
  - csr_wen=1, except RS/RC/RSI/RCI with rs1_idx==0, which do not write.
  - rd_data=old. Go to RESP.
- TRAP: csr_ecall=1, csr_pc=pc, csr_wdata=32'd11 (M-mode ecall cause). Capture csr_rdata (mtvec) into next_pc; redirect=1. Go to RESP.
- Legal CSRs: 0x300, 0x305, 0x341, 0x342. Any other value, including csr[11:10]!=0, sets out_illegal=1.
- RESP: out_valid=1, outputs stable. When out_ready, go to IDLE.

## Timing
- Reset values: in_ready=1; every other output and all internal registers 0; state IDLE. Reset takes effect immediately, mid-operation included, and no strobe survives it.
- CSR strobes (csr_wen, csr_ecall, csr_mret) are registered state decodes. Each is high for exactly the one cycle of its state.
- CSR write lands at the clock edge ending WRITE or TRAP.
- Latency from the accept edge to out_valid:
  - CSR op: 3 cycles (READ, WRITE, RESP).
  - MRET and illegal ops: 2 cycles.
  - ECALL: 2 cycles.
- With out_ready held high, RESP lasts one cycle and in_ready rises the next cycle. Sustained throughput is one CSR op per 4 cycles.
- in_valid outside IDLE is ignored; the upstream stage must hold it.
- out_valid must not drop and outputs must not change until out_ready is sampled high.
- Write-then-read of the same CSR by back-to-back ops returns the new value.

## Test plan
- Reset, then CSRRW 0x305 with rs1_data=0x8000_0100 -> csr_wen for one cycle with waddr=0x305, wdata=0x8000_0100; out_rd_data = prior value (0 after CSR init); out_valid 3 cycles after accept.
- CSRRS 0x300, rs1_idx=0, mstatus=0x1800 -> no csr_wen, rd_data=0x1800. CSRRCI 0x300 with uimm=0x8 -> wdata=0x1800&~0x8=0x1800, wen=1.
- ECALL at pc=0x8000_0040 with mtvec=0x8000_0100 -> csr_ecall one cycle, csr_pc=0x8000_0040, csr_wdata=11; out_redirect=1, out_next_pc=0x8000_0100.
- MRET with mepc=0x8000_0040 -> csr_mret one cycle; next_pc=0x8000_0044 if software wrote mepc+4 beforehand, else exactly the mepc value; redirect=1; no wen.
- CSRRW 0x7C0 -> out_illegal=1, rd_data=0, no wen. Hold out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0 throughout.
- Drop rstn during WRITE -> asynchronous return to IDLE, csr_wen=0 that edge, out_valid=0, in_ready=1.
